// File: rtl/i3c_target_addr_responder_pkg.sv
// i3c_target_addr_responder_pkg: shared widths, broadcast address and target FSM states
package i3c_target_addr_responder_pkg;
  localparam int ADDR_WIDTH = 7;
  localparam logic [ADDR_WIDTH-1:0] BCAST_ADDR = 7'h7E;
  typedef enum logic [1:0] {TGT_IDLE, TGT_ADDR, TGT_ACK, TGT_WAIT} tgt_state_e;
endpackage

// File: rtl/i3c_bus_cond_detect.sv
// i3c_bus_cond_detect: SCL edges and START/STOP conditions from synchronised SCL/SDA
//  clk_i/rst_i: clock, sync active-high reset; scl_i/sda_i: synchronised lines
//  scl_rise_o/scl_fall_o: SCL edges; start_o/stop_o: SDA fall/rise while SCL high
module i3c_bus_cond_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic scl_q, sda_q;
  // History resets to the idle-high bus level so no edge is reported after reset.
  always_ff @(posedge clk_i)
    if (rst_i) {scl_q, sda_q} <= 2'b11;
    else {scl_q, sda_q} <= {scl_i, sda_i};
  assign scl_rise_o = scl_i & ~scl_q;
  assign scl_fall_o = ~scl_i & scl_q;
  assign start_o    = scl_i & scl_q & sda_q & ~sda_i;
  assign stop_o     = scl_i & scl_q & ~sda_q & sda_i;
endmodule

// File: rtl/i3c_target_addr_responder.sv
// i3c_target_addr_responder: target address phase - capture address+RnW, ACK own/broadcast
//  scl_i/sda_i: synchronised bus; dyn_addr_i/dyn_addr_vld_i: assigned dynamic address
//  sda_pull_o: open-drain ACK drive; addr_done_o: ACK slot finished pulse with
//  addr_match_o/bcast_o; rnw_o/rx_addr_o: captured byte; busy_o: START..STOP
module i3c_target_addr_responder
  import i3c_target_addr_responder_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] STATIC_ADDR = 7'h50
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  input  logic [ADDR_WIDTH-1:0] dyn_addr_i,
  input  logic                  dyn_addr_vld_i,
  output logic                  sda_pull_o,
  output logic                  addr_done_o,
  output logic                  addr_match_o,
  output logic                  bcast_o,
  output logic                  rnw_o,
  output logic [ADDR_WIDTH-1:0] rx_addr_o,
  output logic                  busy_o
);
  tgt_state_e state_q, state_d;
  logic [ADDR_WIDTH:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rx_q, rx_d;
  logic pull_q, pull_d, done_q, done_d, match_q, match_d, bcast_q, bcast_d, rnw_q, rnw_d;
  logic own_hit_q, own_hit_d, bc_hit_q, bc_hit_d;
  logic scl_rise, scl_fall, start, stop, own_hit, bc_hit;

  i3c_bus_cond_detect u_cond (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  assign own_hit = shift_q[ADDR_WIDTH:1] == (dyn_addr_vld_i ? dyn_addr_i : STATIC_ADDR);
  assign bc_hit  = shift_q[ADDR_WIDTH:1] == BCAST_ADDR && !shift_q[0];

  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q   <= TGT_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      rx_q      <= '0;
      pull_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      bcast_q   <= 1'b0;
      rnw_q     <= 1'b0;
      own_hit_q <= 1'b0;
      bc_hit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      pull_q    <= pull_d;
      done_q    <= done_d;
      match_q   <= match_d;
      bcast_q   <= bcast_d;
      rnw_q     <= rnw_d;
      own_hit_q <= own_hit_d;
      bc_hit_q  <= bc_hit_d;
    end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    pull_d    = pull_q;
    done_d    = 1'b0;
    match_d   = 1'b0;
    bcast_d   = 1'b0;
    rnw_d     = rnw_q;
    own_hit_d = own_hit_q;
    bc_hit_d  = bc_hit_q;
    if (stop) begin
      state_d = TGT_IDLE;
      cnt_d   = '0;
      pull_d  = 1'b0;
    end else if (start) begin
      state_d = TGT_ADDR;
      cnt_d   = '0;
      shift_d = '0;
      pull_d  = 1'b0;
    end else if (state_q == TGT_ADDR) begin
      if (scl_rise && cnt_q != 4'd8) begin
        shift_d = {shift_q[ADDR_WIDTH-1:0], sda_i};
        cnt_d   = cnt_q + 4'd1;
      end else if (scl_fall && cnt_q == 4'd8) begin
        // Match result is frozen here so later dynamic-address updates cannot alter this ACK.
        state_d   = TGT_ACK;
        rx_d      = shift_q[ADDR_WIDTH:1];
        rnw_d     = shift_q[0];
        own_hit_d = own_hit;
        bc_hit_d  = bc_hit;
        pull_d    = own_hit | bc_hit;
      end
    end else if (state_q == TGT_ACK && scl_fall) begin
      state_d = TGT_WAIT;
      pull_d  = 1'b0;
      done_d  = 1'b1;
      match_d = own_hit_q;
      bcast_d = bc_hit_q;
    end
  end

  assign sda_pull_o   = pull_q;
  assign addr_done_o  = done_q;
  assign addr_match_o = match_q;
  assign bcast_o      = bcast_q;
  assign rnw_o        = rnw_q;
  assign rx_addr_o    = rx_q;
  assign busy_o       = state_q != TGT_IDLE;
endmodule

// File: tb/tb_i3c_target_addr_responder.sv
// tb_i3c_target_addr_responder: directed and randomized address-phase checks against a spec-level model
module tb_i3c_target_addr_responder;
  localparam int P = 3;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda = 1'b1, dyn_vld = 1'b0;
  logic [6:0] dyn = 7'h00;
  logic sda_pull, addr_done, addr_match, bcast, rnw, busy;
  logic [6:0] rx_addr;
  int errs = 0, checks = 0, done_cnt = 0, exp_done = 0;

  i3c_target_addr_responder dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .scl_i         (scl),
    .sda_i         (sda),
    .dyn_addr_i    (dyn),
    .dyn_addr_vld_i(dyn_vld),
    .sda_pull_o    (sda_pull),
    .addr_done_o   (addr_done),
    .addr_match_o  (addr_match),
    .bcast_o       (bcast),
    .rnw_o         (rnw),
    .rx_addr_o     (rx_addr),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (addr_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      sda = 1'b1; tick(P);
      scl = 1'b1; tick(P);
    end
    sda = 1'b0; tick(P);
    scl = 1'b0; tick(1);
    check("busy_start", busy, 1);
    tick(P);
  endtask

  task automatic bus_stop();
    sda = 1'b0; tick(P);
    scl = 1'b1; tick(P);
    sda = 1'b1; tick(1);
    check("busy_stop", busy, 0);
    check("pull_stop", sda_pull, 0);
    tick(P);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda = b[7-i]; tick(P);
      scl = 1'b1; tick(P);
      scl = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] b, input bit flip);
    logic [6:0] own;
    bit m, bc;
    own = dyn_vld ? dyn : 7'h50;
    m   = b[7:1] == own;
    bc  = b[7:1] == 7'h7E && b[0] == 1'b0;
    send_bits(b, 8);
    tick(1);
    check("ack_latency", sda_pull, m | bc);
    if (flip) begin
      dyn_vld = ~dyn_vld;
      dyn = 7'($urandom_range(0, 7'h7D));
    end
    sda = 1'b1; tick(P);
    scl = 1'b1; tick(P);
    check("ack_hold", sda_pull, m | bc);
    scl = 1'b0; tick(1);
    check("done_pulse", addr_done, 1);
    check("addr_match", addr_match, m);
    check("bcast", bcast, bc);
    exp_done++;
    tick(1);
    check("done_one_cycle", addr_done, 0);
    check("ack_release", sda_pull, 0);
    check("rx_addr", rx_addr, b[7:1]);
    check("rnw", rnw, b[0]);
    check("busy_wait", busy, 1);
    tick(P);
  endtask

  initial begin
    logic [7:0] b;
    tick(3);
    check("rst_pull", sda_pull, 0);
    check("rst_done", addr_done, 0);
    check("rst_match", addr_match, 0);
    check("rst_bcast", bcast, 0);
    check("rst_rnw", rnw, 0);
    check("rst_rx", rx_addr, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; tick(2);

    bus_start(); xfer(8'hA0, 0); bus_stop();

    dyn = 7'h31; dyn_vld = 1'b1;
    bus_start(); xfer(8'h63, 0);
    bus_start(); xfer(8'hA0, 0); bus_stop();
    dyn_vld = 1'b0;

    bus_start(); xfer(8'hFC, 0);
    bus_start(); xfer(8'hFD, 0); bus_stop();

    bus_start(); send_bits(8'hA0, 4);
    bus_start(); xfer(8'hA0, 0); bus_stop();
    check("abort_done_count", done_cnt, exp_done);

    bus_start(); send_bits(8'hA0, 8); tick(1);
    check("stop_ack_pull", sda_pull, 1);
    sda = 1'b0; tick(P);
    scl = 1'b1; tick(P);
    check("stop_ack_hold", sda_pull, 1);
    sda = 1'b1; tick(1);
    check("stop_ack_release", sda_pull, 0);
    check("stop_ack_busy", busy, 0);
    tick(P);
    check("stop_ack_no_done", done_cnt, exp_done);

    bus_start(); send_bits(8'hA0, 8); tick(1);
    check("rst_mid_pull", sda_pull, 1);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    check("rst_mid_pull_off", sda_pull, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rx", rx_addr, 0);
    check("rst_mid_done", addr_done, 0);
    sda = 1'b1; tick(P);
    scl = 1'b1; tick(P);
    bus_start(); xfer(8'hA0, 0); bus_stop();

    for (int i = 0; i < 40; i++) begin
      dyn_vld = 1'($urandom_range(0, 1));
      dyn = 7'($urandom_range(0, 7'h7D));
      case ($urandom_range(0, 3))
        0: b = 8'($urandom);
        1: b = {(dyn_vld ? dyn : 7'h50), 1'($urandom_range(0, 1))};
        2: b = {7'h7E, 1'($urandom_range(0, 1))};
        default: b = {7'h50, 1'($urandom_range(0, 1))};
      endcase
      bus_start();
      xfer(b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) bus_stop();
    end
    bus_stop();
    tick(2);
    check("total_done_count", done_cnt, exp_done);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
